// File: rtl/controlador_mac_pkg.sv
// controlador_mac_pkg: state encodings and default sizes shared by the MAC sequencer.
package controlador_mac_pkg;
  localparam logic [1:0] OCIOSO  = 2'd0;
  localparam logic [1:0] LIMPA   = 2'd1;
  localparam logic [1:0] ACUMULA = 2'd2;
  localparam logic [1:0] FIM     = 2'd3;
  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 8;
endpackage

// File: rtl/controlador_mac_acumulador_hab.sv
// acumulador_hab: unsigned multiplier, adder and accumulator register with write-enable and sync clear.
module acumulador_hab #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               en_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic               carry_o
);
  logic [2*WIDTH-1:0] acc_q, acc_d, prod;
  logic [2*WIDTH:0]   sum;
  always_comb begin
    prod = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};
    sum = {1'b0, acc_q} + {1'b0, prod};
    acc_d = clr_i ? '0 : en_i ? sum[2*WIDTH-1:0] : acc_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) acc_q <= '0;
    else acc_q <= acc_d;
  assign acc_o = acc_q;
  assign carry_o = sum[2*WIDTH];
endmodule

// File: rtl/controlador_mac.sv
// controlador_mac: sequences a run of N operand pairs into the accumulator and reports the dot product.
module controlador_mac
  import controlador_mac_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic               p_Clock,
  input  logic               p_Clear,
  input  logic               p_Start,
  input  logic [CNT_W-1:0]   p_N,
  input  logic [WIDTH-1:0]   p_A,
  input  logic [WIDTH-1:0]   p_B,
  input  logic               p_Valid,
  output logic               p_Ready,
  output logic               p_Busy,
  output logic               p_Done,
  output logic [2*WIDTH-1:0] p_Result,
  output logic               p_Overflow
);
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d, cnt_q, cnt_d, cnt_nx;
  logic             ovf_q, ovf_d, accept, last, clr, carry;
  assign p_Ready = state_q == ACUMULA;
  assign p_Busy = state_q != OCIOSO;
  assign p_Done = state_q == FIM;
  assign p_Overflow = ovf_q;
  always_comb begin
    clr = state_q == LIMPA;
    accept = p_Valid & p_Ready;
    cnt_nx = cnt_q + 1'b1;
    last = accept && (cnt_nx == n_q);
    state_d = (state_q == OCIOSO) ? (p_Start ? LIMPA : OCIOSO) :
              (state_q == LIMPA) ? ((n_q == '0) ? FIM : ACUMULA) :
              (state_q == ACUMULA) ? (last ? FIM : ACUMULA) : OCIOSO;
    n_d = (state_q == OCIOSO && p_Start) ? p_N : n_q;
    cnt_d = clr ? '0 : accept ? cnt_nx : cnt_q;
    ovf_d = clr ? 1'b0 : accept ? (ovf_q | carry) : ovf_q;
  end
  always_ff @(posedge p_Clock or posedge p_Clear)
    if (p_Clear) begin
      state_q <= OCIOSO;
      n_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  acumulador_hab #(.WIDTH(WIDTH)) u_acc (
    .clk(p_Clock),
    .rst(p_Clear),
    .clr_i(clr),
    .en_i(accept),
    .a_i(p_A),
    .b_i(p_B),
    .acc_o(p_Result),
    .carry_o(carry)
  );
endmodule
